// File: rtl/uart_pkg.sv
// Shared definitions for the UART command queue: command width, issue FSM
// state encoding and the default transmitter busy timeout.
package uart_pkg;

    localparam int CMD_W        = 16;
    localparam int BUSY_TMO_DEF = 4;

    typedef logic [CMD_W-1:0] cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } issue_state_t;

endpackage

// File: rtl/uart_cmd_queue_if.sv
// Host-side write handshake and transmitter-side issue handshake of the
// command queue; slave is the queue's view, master the driver's view.
interface uart_cmd_queue_if;
    import uart_pkg::*;

    cmd_t in_data;
    logic in_vld;
    logic in_rdy;
    cmd_t cmd_in;
    logic cmd_vld;
    logic cmd_rdy;

    modport slave (
        input  in_data, in_vld, cmd_rdy,
        output in_rdy, cmd_in, cmd_vld
    );

    modport master (
        output in_data, in_vld, cmd_rdy,
        input  in_rdy, cmd_in, cmd_vld
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full, empty and
// level all come straight from registered state.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [LW-1:0]    w_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == LW'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + LW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
        end
    end

    // Storage needs no reset; only pointer-qualified words are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_cmd_queue.sv
// Command queue feeding a UART transmitter: buffers host commands and issues
// them one at a time, watching that the transmitter actually goes busy.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | nothing outstanding; pop head when queue non-empty and tx idle
// ST_ISSUE     | cmd_vld high for this single cycle
// ST_WAIT_BUSY | waiting for tx to drop cmd_rdy; timeout sets tmo_err
// ST_WAIT_DONE | tx busy sending the frame pair; wait for cmd_rdy to return
module uart_cmd_queue
    import uart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BUSY_TMO = BUSY_TMO_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_cmd_queue_if.slave        bus,
    input  logic                   i_clr_err,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_ovf_err,
    output logic                   o_tmo_err
);

    localparam int TMO_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TMO - 1);

    issue_state_t     r_state;
    issue_state_t     w_state_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    cmd_t             r_cmd_in;
    logic             r_cmd_vld;
    logic             r_ovf_err;
    logic             r_tmo_err;

    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_tmo_hit;

    assign w_push    = bus.in_vld && !w_full;
    assign w_ovf_set = bus.in_vld && w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && bus.cmd_rdy;

    assign bus.in_rdy  = !w_full;
    assign bus.cmd_in  = r_cmd_in;
    assign bus.cmd_vld = r_cmd_vld;
    assign o_ovf_err   = r_ovf_err;
    assign o_tmo_err   = r_tmo_err;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.in_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_hit   = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_pop) w_state_nxt = ST_ISSUE;
            ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!bus.cmd_rdy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_tmo_cnt == '0) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (bus.cmd_rdy) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Down-counter armed during ISSUE so WAIT_BUSY lasts at most BUSY_TMO cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if ((r_state == ST_WAIT_BUSY) && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_in  <= '0;
            r_cmd_vld <= 1'b0;
        end else begin
            r_cmd_vld <= w_pop;
            if (w_pop) r_cmd_in <= w_head;
        end
    end

    // A set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_ovf_set)      r_ovf_err <= 1'b1;
            else if (i_clr_err) r_ovf_err <= 1'b0;
            if (w_tmo_hit)      r_tmo_err <= 1'b1;
            else if (i_clr_err) r_tmo_err <= 1'b0;
        end
    end

endmodule

// File: doc/uart_cmd_queue.md
UART_CMD_QUEUE -- requirements
Module: uart_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue depth in 16-bit commands; SHALL be a power of 2, at least 2.
REQ-002 Parameter BUSY_TMO, default 4, cycles allowed for the transmitter to drop cmd_rdy after an issue.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  16  command from the host; [15:8] is sent first, [7:0] second.
REQ-006 in_vld  input  1  in_data valid.
REQ-007 in_rdy  output  1  queue can accept a command.
REQ-008 cmd_in  output  16  command presented to the UART transmitter.
REQ-009 cmd_vld  output  1  single-cycle issue strobe to the transmitter.
REQ-010 cmd_rdy  input  1  transmitter idle; low while a frame pair is being sent.
REQ-011 level  output  $clog2(DEPTH)+1  number of stored commands.
REQ-012 ovf_err  output  1  sticky: write attempted while full.
REQ-013 tmo_err  output  1  sticky: transmitter failed to go busy within BUSY_TMO cycles.
REQ-014 clr_err  input  1  synchronous clear of ovf_err and tmo_err.

Function
REQ-015 in_rdy SHALL equal !full; full is computed from registered pointers only, so a same-cycle pop SHALL NOT raise in_rdy.
REQ-016 A write SHALL occur when in_vld && in_rdy; data is stored at wr_ptr, and wr_ptr wraps modulo DEPTH.
REQ-017 in_vld while full SHALL drop the data and set ovf_err on the next edge; pointers are unchanged.
REQ-018 level SHALL update one cycle after each push or pop; a simultaneous push and pop leaves it unchanged.
REQ-019 The issue FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-020 IDLE -> ISSUE when !empty && cmd_rdy; on that edge the head word is loaded into cmd_in and rd_ptr advances (pop).
REQ-021 In ISSUE, cmd_vld = 1 for exactly one cycle, then the FSM moves unconditionally to WAIT_BUSY.
REQ-022 WAIT_BUSY -> WAIT_DONE when cmd_rdy == 0.
REQ-023 If cmd_rdy stays 1 for BUSY_TMO cycles in WAIT_BUSY, the FSM SHALL set tmo_err and return to IDLE; the command is discarded, not retried.
REQ-024 WAIT_DONE -> IDLE when cmd_rdy == 1.
REQ-025 cmd_in SHALL stay stable from ISSUE until the next pop.
REQ-026 Latency: a command written at edge N into an empty queue, with cmd_rdy high, SHALL give cmd_vld high in cycle N+2.
REQ-027 Back-to-back commands SHALL be issued strictly in FIFO order, at most one outstanding at a time.
REQ-028 If clr_err and an error set occur in the same cycle, the set SHALL win.
REQ-029 cmd_vld SHALL be a registered output, with no combinational path from cmd_rdy.

Reset
REQ-030 On rst_n low: pointers = 0, level = 0, FSM = IDLE, cmd_vld = 0, cmd_in = 16'h0000, ovf_err = 0, tmo_err = 0; in_rdy = 1 once reset is released.
REQ-031 Reset mid-operation SHALL abandon the in-flight command and all queued contents; no cmd_vld in the first cycle after release.

Structure
REQ-032 The shared package uart_pkg SHALL hold CMD_W = 16, the FSM state enum and the default BUSY_TMO.
REQ-033 Storage and pointers SHALL live in one sub-module, sync_fifo (parameters width and depth; ports push, pop, full, empty, level); the FSM and error flags stay in the top level.

Verification
REQ-034 Single command: push 16'hA55A into an empty queue with cmd_rdy high -> cmd_vld pulses at N+2 with cmd_in = 16'hA55A; the model drops cmd_rdy for 22 cycles; the FSM returns to IDLE.
REQ-035 Ordering: push 16'h0001..16'h0008 back-to-back with DEPTH = 8 -> in_rdy goes low after the 8th; issue order is 0001..0008; level returns to 0.
REQ-036 Overflow: a 9th push (16'hFFFF) while full -> ovf_err = 1, 16'hFFFF never issued; clr_err pulse -> ovf_err = 0.
REQ-037 Timeout: cmd_rdy held high after issue -> tmo_err = 1 after 4 cycles, FSM in IDLE, the next queued command issues normally.
REQ-038 Wrap and concurrency: push and pop in the same cycle at level 3 -> level stays 3; 20 commands through DEPTH = 8 -> all arrive in order with correct pointer wrap.
REQ-039 Reset in WAIT_DONE with 3 queued -> after release level = 0, cmd_vld = 0, in_rdy = 1.
